// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with synchroniser, parity/framing/overrun flags and show-ahead FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 state, state_n;
    logic                   rx_meta, rx_s;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   pend_perr, perr_n;
    logic                   push, set_ferr, set_perr;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   full, do_pop, do_push, set_ovr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            pend_perr <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            pend_perr <= perr_n;
        end
    end

    // cnt is cleared on every state change so each state measures from its own entry
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        perr_n   = pend_perr;
        push     = 1'b0;
        set_ferr = 1'b0;
        set_perr = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    perr_n  = 1'b0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n        = '0;
                    shreg_n[idx] = rx_s;
                    if (idx == IDX_LAST)
                        state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    else
                        idx_n = idx + IW'(1);
                end
            end
            S_PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    perr_n  = rx_s != ((^shreg) ^ ODD);
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n  = S_IDLE;
                        set_perr = pend_perr;
                        push     = !pend_perr;
                    end else begin
                        set_ferr = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot the full-FIFO push needs
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign set_ovr = push && full && !do_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            frame_err  <= set_ferr | (frame_err  & ~err_clr);
            parity_err <= set_perr | (parity_err & ~err_clr);
            overrun    <= set_ovr  | (overrun    & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed checks of uart_rx_fifo against a frame-level queue model
module tb_uart_rx_fifo;

    localparam int CPB    = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_drv = 1'b1;
    logic        rd_en_drv = 1'b0;
    logic        err_clr_drv = 1'b0;
    bit          sel = 1'b0;

    logic        rx0, rd_en0, err_clr0, rd_valid0, fe0, pe0, ov0;
    logic        rx1, rd_en1, err_clr1, rd_valid1, fe1, pe1, ov1;
    logic [7:0]  rd_data0, rd_data1;
    logic [2:0]  cnt0, cnt1;
    logic [14:0] st;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mq[$];
    logic        m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    assign rx0      = sel ? 1'b1 : rx_drv;
    assign rx1      = sel ? rx_drv : 1'b1;
    assign rd_en0   = sel ? 1'b0 : rd_en_drv;
    assign rd_en1   = sel ? rd_en_drv : 1'b0;
    assign err_clr0 = sel ? 1'b0 : err_clr_drv;
    assign err_clr1 = sel ? err_clr_drv : 1'b0;
    assign st = sel ? {rd_valid1, rd_data1, cnt1, fe1, pe1, ov1}
                    : {rd_valid0, rd_data0, cnt0, fe0, pe0, ov0};

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .fifo_count(cnt0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .err_clr(err_clr0));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .fifo_count(cnt1), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .err_clr(err_clr1));

    function automatic logic [14:0] exp_st();
        logic [7:0] h;
        h = (mq.size() != 0) ? mq[0] : 8'h00;
        return {mq.size() != 0, h, 3'(mq.size()), m_ferr, m_perr, m_ovr};
    endfunction

    // Drives one frame bit-by-bit on falling edges; pop_at selects the edge index carrying rd_en
    task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                        input int pop_at, input bit hold);
        logic [10:0] bits;
        int nb;
        nb      = sel ? 11 : 10;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (sel) begin
            bits[9]  = (^d) ^ bad_par;
            bits[10] = !bad_stop;
        end else begin
            bits[9]  = !bad_stop;
        end
        for (int i = 0; i < nb * CPB; i++) begin
            @(negedge clk);
            rx_drv    = bits[i / CPB];
            rd_en_drv = (i == pop_at);
        end
        @(negedge clk);
        rd_en_drv = 1'b0;
        if (!hold) begin
            rx_drv = 1'b1;
            repeat (6) @(negedge clk);
        end
        if (bad_stop) m_ferr = 1'b1;
        else if (sel && bad_par) m_perr = 1'b1;
        else begin
            if (pop_at >= 0 && mq.size() != 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en_drv = 1'b1;
        @(negedge clk);
        rd_en_drv = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic clr();
        @(negedge clk);
        err_clr_drv = 1'b1;
        @(negedge clk);
        err_clr_drv = 1'b0;
        m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++;
            if (st !== 15'h0) begin
                miscompares++;
                $display("FAIL reset_sel%0d: got %h want %h", s, st, 15'h0);
            end
        end
        sel = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        sel = 1'b0;
        send(8'hA5, 0, 0, -1, 0);
        vectors++;
        if (st !== {1'b1, 8'hA5, 3'd1, 3'b000}) begin
            miscompares++;
            $display("FAIL basic_a5: got %h want %h", st, {1'b1, 8'hA5, 3'd1, 3'b000});
        end
        pop_one();
        vectors++;
        if (st !== 15'h0) begin
            miscompares++;
            $display("FAIL basic_pop: got %h want %h", st, 15'h0);
        end
    endtask

    task automatic test_glitch();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_drv = 1'b0;
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (st !== exp_st()) begin
            miscompares++;
            $display("FAIL glitch_idle: got %h want %h", st, exp_st());
        end
        send(8'h3C, 0, 0, -1, 0);
        vectors++;
        if (st !== exp_st()) begin
            miscompares++;
            $display("FAIL glitch_next: got %h want %h", st, exp_st());
        end
        pop_one();
    endtask

    task automatic test_parity();
        sel = 1'b1;
        send(8'h03, 1, 0, -1, 0);
        vectors++;
        if (st !== {1'b0, 8'h00, 3'd0, 3'b010}) begin
            miscompares++;
            $display("FAIL parity_bad: got %h want %h", st, {1'b0, 8'h00, 3'd0, 3'b010});
        end
        send(8'h03, 0, 0, -1, 0);
        vectors++;
        if (st !== {1'b1, 8'h03, 3'd1, 3'b010}) begin
            miscompares++;
            $display("FAIL parity_good: got %h want %h", st, {1'b1, 8'h03, 3'd1, 3'b010});
        end
        clr();
        vectors++;
        if (st !== exp_st()) begin
            miscompares++;
            $display("FAIL parity_clr: got %h want %h", st, exp_st());
        end
        pop_one();
        sel = 1'b0;
    endtask

    task automatic test_break();
        sel = 1'b0;
        send(8'h55, 0, 1, -1, 1);
        vectors++;
        if (st !== {1'b0, 8'h00, 3'd0, 3'b100}) begin
            miscompares++;
            $display("FAIL break_ferr: got %h want %h", st, {1'b0, 8'h00, 3'd0, 3'b100});
        end
        clr();
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (st !== 15'h0) begin
            miscompares++;
            $display("FAIL break_once: got %h want %h", st, 15'h0);
        end
        send(8'h0F, 0, 0, -1, 0);
        vectors++;
        if (st !== exp_st()) begin
            miscompares++;
            $display("FAIL break_next: got %h want %h", st, exp_st());
        end
        pop_one();
    endtask

    task automatic test_overrun();
        sel = 1'b0;
        for (int b = 0; b < 5; b++) send(8'h10 + 8'(b), 0, 0, -1, 0);
        vectors++;
        if (st[5:3] !== 3'd4 || st[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_full: got count %0d ovr %b want count 4 ovr 1", st[5:3], st[0]);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (st[13:6] !== 8'h10 + 8'(k) || st !== exp_st()) begin
                miscompares++;
                $display("FAIL overrun_read%0d: got %h want data %h", k, st, 8'h10 + 8'(k));
            end
            pop_one();
        end
        clr();
        vectors++;
        if (st !== 15'h0) begin
            miscompares++;
            $display("FAIL overrun_empty: got %h want %h", st, 15'h0);
        end
    endtask

    task automatic test_full_pop();
        sel = 1'b0;
        for (int b = 0; b < 4; b++) send(8'h20 + 8'(b), 0, 0, -1, 0);
        send(8'h24, 0, 0, 2 + CPB / 2 + 9 * CPB, 0);
        vectors++;
        if (st !== {1'b1, 8'h21, 3'd4, 3'b000}) begin
            miscompares++;
            $display("FAIL fullpop_state: got %h want %h", st, {1'b1, 8'h21, 3'd4, 3'b000});
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (st[13:6] !== 8'h21 + 8'(k)) begin
                miscompares++;
                $display("FAIL fullpop_read%0d: got %h want %h", k, st[13:6], 8'h21 + 8'(k));
            end
            pop_one();
        end
    endtask

    task automatic test_reset_midframe();
        sel = 1'b0;
        send(8'h77, 0, 0, -1, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rx_drv = (i < CPB) ? 1'b0 : 1'($urandom);
        end
        reset_n = 1'b0;
        rx_drv  = 1'b1;
        #1;
        mq.delete();
        m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
        vectors++;
        if (st !== 15'h0) begin
            miscompares++;
            $display("FAIL midreset_out: got %h want %h", st, 15'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h99, 0, 0, -1, 0);
        vectors++;
        if (st !== {1'b1, 8'h99, 3'd1, 3'b000}) begin
            miscompares++;
            $display("FAIL midreset_next: got %h want %h", st, {1'b1, 8'h99, 3'd1, 3'b000});
        end
        pop_one();
    endtask

    task automatic test_random(input bit s);
        logic [7:0] d;
        bit bp, bs;
        sel = s;
        for (int n = 0; n < 20; n++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(0, 7) == 0);
            bp = s && ($urandom_range(0, 5) == 0);
            send(d, bp, bs, -1, 0);
            vectors++;
            if (st !== exp_st()) begin
                miscompares++;
                $display("FAIL random_s%0d_frame%0d: got %h want %h", s, n, st, exp_st());
            end
            for (int p = $urandom_range(0, 2); p > 0; p--) begin
                pop_one();
                vectors++;
                if (st !== exp_st()) begin
                    miscompares++;
                    $display("FAIL random_s%0d_pop%0d: got %h want %h", s, n, st, exp_st());
                end
            end
            if ($urandom_range(0, 9) == 0) clr();
        end
        while (mq.size() != 0) pop_one();
        clr();
        vectors++;
        if (st !== 15'h0) begin
            miscompares++;
            $display("FAIL random_s%0d_drain: got %h want %h", s, st, 15'h0);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_full_pop();
        test_reset_midframe();
        test_random(1'b0);
        test_random(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
